// File: rtl/mips16_mc_control.sv
// Multi-cycle MIPS16 control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Memory accesses wait on mem_ready with an optional timeout; hold freezes all state and zeroes every strobe.
module mips16_mc_control #(
   parameter int OPCODE_W    = 6,
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                hold,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                ir_write,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                sign_or_zero,
   output logic                illegal,
   output logic                bus_error,
   output logic                retire,
   output logic [CNT_W-1:0]    retired_cnt,
   output logic [2:0]          state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_BRANCH = 3'd6;
   localparam logic [2:0] S_JUMP   = 3'd7;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LI   = 6'b011000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   logic [5:0]        opcode_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [2:0]        state_d;
   logic [2:0]        alu_op3;
   logic              op_hi_zero;
   logic              in_wait;
   logic              timeout;
   logic              is_r, is_lw, is_sw, is_beq, is_bne, is_jal;

   // Only opcode_q's low six bits are kept; illegal upper bits never reach EXEC.
   generate
      if (OPCODE_W > 6) begin : g_hi
         assign op_hi_zero = ~|opcode[OPCODE_W-1:6];
      end else begin : g_nohi
         assign op_hi_zero = 1'b1;
      end
   endgenerate

   assign is_r   = (opcode_q == OP_R);
   assign is_lw  = (opcode_q == OP_LW);
   assign is_sw  = (opcode_q == OP_SW);
   assign is_beq = (opcode_q == OP_BEQ);
   assign is_bne = (opcode_q == OP_BNE);
   assign is_jal = (opcode_q == OP_JAL);

   assign in_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
   assign timeout = (MEM_TIMEOUT != 0) && in_wait && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

   assign sign_or_zero = 1'b1;
   assign bus_error    = timeout && !hold;
   assign alu_op       = ALU_OP_W'(alu_op3);

   always_comb begin
      state_d    = state;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op3    = 3'b000;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      illegal    = 1'b0;
      retire     = 1'b0;
      case (state)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_FETCH;
            illegal = 1'b1;
            if (op_hi_zero) begin
               case (opcode[5:0])
                  OP_R, OP_ADDI, OP_LI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: begin
                     state_d = S_EXEC;
                     illegal = 1'b0;
                  end
                  OP_BEQ, OP_BNE: begin
                     state_d = S_BRANCH;
                     illegal = 1'b0;
                  end
                  OP_J, OP_JAL: begin
                     state_d = S_JUMP;
                     illegal = 1'b0;
                  end
                  default: ;
               endcase
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = is_r ? 2'b00 : 2'b10;
            case (opcode_q)
               OP_R:    alu_op3 = 3'b110;
               OP_SLTI: alu_op3 = 3'b101;
               OP_ANDI: alu_op3 = 3'b010;
               OP_ORI:  alu_op3 = 3'b011;
               default: alu_op3 = 3'b000;
            endcase
            state_d = (is_lw || is_sw) ? S_MEM : S_WB;
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = is_lw;
            mem_write = is_sw;
            if (mem_ready) begin
               state_d = is_lw ? S_WB : S_FETCH;
               retire  = is_sw;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_r ? 2'b01 : 2'b00;
            mem_to_reg = is_lw ? 2'b01 : 2'b00;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op3   = 3'b001;
            pc_src    = 2'b01;
            pc_write  = (is_beq && zero) || (is_bne && !zero);
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            if (is_jal) begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      // A timeout only fires while mem_ready is low, so retire is already 0 here.
      if (timeout) begin
         state_d   = S_FETCH;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
      end

      if (hold) begin
         state_d   = state;
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
         illegal   = 1'b0;
         retire    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         opcode_q    <= '0;
         wait_cnt    <= '0;
         retired_cnt <= '0;
      end else if (!hold) begin
         state <= state_d;
         if (state == S_DECODE) opcode_q <= opcode[5:0];
         wait_cnt <= (in_wait && !timeout) ? wait_cnt + 1'b1 : '0;
         if (retire) retired_cnt <= retired_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips16_mc_control.sv
// Bench for mips16_mc_control: per-instruction expected cycle traces built from the instruction rules,
// replayed against the DUT cycle by cycle; a second small-counter instance checks counter wrap.
module tb_mips16_mc_control;

   localparam int OW = 8;
   localparam int AW = 4;
   localparam int TO = 4;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3;
   localparam logic [2:0] ST_MEM = 3'd4, ST_WB = 3'd5, ST_BRANCH = 3'd6, ST_JUMP = 3'd7;

   localparam int C_ILL = 0, C_R = 1, C_ADDI = 2, C_SLTI = 3, C_ANDI = 4, C_ORI = 5;
   localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_BNE = 9, C_J = 10, C_JAL = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, zero, mem_ready, hold;
   logic [OW-1:0] opcode;
   logic          pc_write, ir_write, i_or_d, mem_read, mem_write, alu_src_a, reg_write;
   logic [1:0]    pc_src, alu_src_b, reg_dst, mem_to_reg;
   logic [AW-1:0] alu_op;
   logic          sign_or_zero, illegal, bus_error, retire;
   logic [15:0]   retired_cnt;
   logic [2:0]    state;

   mips16_mc_control #(.OPCODE_W(OW), .ALU_OP_W(AW), .MEM_TIMEOUT(TO), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .hold(hold),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .sign_or_zero(sign_or_zero), .illegal(illegal), .bus_error(bus_error), .retire(retire),
      .retired_cnt(retired_cnt), .state(state)
   );

   logic       reset_b, zero_b, mem_ready_b, hold_b;
   logic [5:0] opcode_b;
   logic       pc_write_b, ir_write_b, i_or_d_b, mem_read_b, mem_write_b, alu_src_a_b, reg_write_b;
   logic [1:0] pc_src_b, alu_src_b_b, reg_dst_b, mem_to_reg_b;
   logic [2:0] alu_op_b;
   logic       sign_or_zero_b, illegal_b, bus_error_b, retire_b;
   logic [1:0] retired_cnt_b;
   logic [2:0] state_b;

   mips16_mc_control #(.CNT_W(2)) u_dut_b (
      .clk(clk), .reset(reset_b), .opcode(opcode_b), .zero(zero_b), .mem_ready(mem_ready_b), .hold(hold_b),
      .pc_write(pc_write_b), .pc_src(pc_src_b), .ir_write(ir_write_b), .i_or_d(i_or_d_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
      .alu_op(alu_op_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
      .sign_or_zero(sign_or_zero_b), .illegal(illegal_b), .bus_error(bus_error_b), .retire(retire_b),
      .retired_cnt(retired_cnt_b), .state(state_b)
   );

   typedef struct {
      logic [2:0] st;
      logic [7:0] op;
      logic       z, rdy, hld, full;
      logic       pw, irw, iod, mr, mw, asa, rw, ill, berr, ret;
      logic [1:0] ps, asb, rd, m2r;
      logic [2:0] aop;
   } cyc_t;

   cyc_t        exp_q[$];
   int          n_chk, n_pass;
   logic [15:0] cnt_model;
   bit          hold_en;
   logic [7:0]  legal_ops[12];

   function automatic int op_class(input logic [7:0] op);
      if (op[7:6] != 2'b00) return C_ILL;
      case (op[5:0])
         6'h00:        return C_R;
         6'h08, 6'h18: return C_ADDI;
         6'h0A:        return C_SLTI;
         6'h0C:        return C_ANDI;
         6'h0D:        return C_ORI;
         6'h23:        return C_LW;
         6'h2B:        return C_SW;
         6'h04:        return C_BEQ;
         6'h05:        return C_BNE;
         6'h02:        return C_J;
         6'h03:        return C_JAL;
         default:      return C_ILL;
      endcase
   endfunction

   function automatic cyc_t blank(input logic [2:0] st, input logic [7:0] op, input logic z);
      cyc_t c;
      c.st = st; c.op = op; c.z = z; c.rdy = 1'($urandom_range(0, 1)); c.hld = 1'b0; c.full = 1'b1;
      c.pw = 0; c.irw = 0; c.iod = 0; c.mr = 0; c.mw = 0; c.asa = 0; c.rw = 0;
      c.ill = 0; c.berr = 0; c.ret = 0;
      c.ps = 2'b00; c.asb = 2'b00; c.rd = 2'b00; c.m2r = 2'b00; c.aop = 3'b000;
      return c;
   endfunction

   // Optionally precede a cycle with a frozen copy of itself: no strobes, no pulses, same state.
   task automatic add(input cyc_t c);
      cyc_t h;
      if (hold_en && $urandom_range(0, 5) == 0) begin
         h = c; h.hld = 1'b1; h.full = 1'b0; h.rdy = 1'($urandom_range(0, 1));
         h.pw = 0; h.irw = 0; h.mr = 0; h.mw = 0; h.rw = 0; h.ill = 0; h.berr = 0; h.ret = 0;
         exp_q.push_back(h);
      end
      exp_q.push_back(c);
   endtask

   task automatic plan_access(input cyc_t wait_c, input cyc_t done_c, input int waits,
                              input bit retry, output bit aborted);
      int   rem;
      cyc_t e;
      rem = waits;
      aborted = 1'b0;
      while (rem > TO) begin
         for (int i = 0; i < TO; i++) add(wait_c);
         e = wait_c; e.full = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.berr = 1'b1;
         add(e);
         rem -= TO + 1;
         if (!retry) begin
            aborted = 1'b1;
            return;
         end
      end
      for (int i = 0; i < rem; i++) add(wait_c);
      add(done_c);
   endtask

   task automatic plan_instr(input logic [7:0] op, input logic z, input int fwait, input int mwait);
      cyc_t c, d;
      int   k;
      bit   ab;
      k = op_class(op);
      c = blank(ST_FETCH, op, z); c.mr = 1; c.asb = 2'b01; c.rdy = 0;
      d = c; d.rdy = 1; d.irw = 1; d.pw = 1;
      plan_access(c, d, fwait, 1'b1, ab);
      c = blank(ST_DECODE, op, z);
      c.ill = (k == C_ILL);
      add(c);
      if (k == C_ILL) return;
      case (k)
         C_BEQ, C_BNE: begin
            c = blank(ST_BRANCH, op, z); c.asa = 1; c.aop = 3'd1; c.ps = 2'b01;
            c.pw = (k == C_BEQ) ? z : ~z; c.ret = 1;
            add(c);
         end
         C_J, C_JAL: begin
            c = blank(ST_JUMP, op, z); c.pw = 1; c.ps = 2'b10; c.ret = 1;
            if (k == C_JAL) begin c.rw = 1; c.rd = 2'b10; c.m2r = 2'b10; end
            add(c);
         end
         default: begin
            c = blank(ST_EXEC, op, z); c.asa = 1;
            c.asb = (k == C_R) ? 2'b00 : 2'b10;
            c.aop = (k == C_R) ? 3'd6 : (k == C_SLTI) ? 3'd5 : (k == C_ANDI) ? 3'd2 :
                    (k == C_ORI) ? 3'd3 : 3'd0;
            add(c);
            if (k == C_LW || k == C_SW) begin
               c = blank(ST_MEM, op, z); c.iod = 1; c.mr = (k == C_LW); c.mw = (k == C_SW); c.rdy = 0;
               d = c; d.rdy = 1; d.ret = (k == C_SW);
               plan_access(c, d, mwait, 1'b0, ab);
               if (ab || k == C_SW) return;
            end
            c = blank(ST_WB, op, z); c.rw = 1; c.ret = 1;
            c.rd  = (k == C_R) ? 2'b01 : 2'b00;
            c.m2r = (k == C_LW) ? 2'b01 : 2'b00;
            add(c);
         end
      endcase
   endtask

   // Replays queued cycles; entered and left just after a rising edge.
   task automatic run_queue(input int max, input string tag);
      cyc_t        c;
      logic [7:0]  so, se;
      logic [14:0] lo, le;
      int          n;
      n = 0;
      while (exp_q.size() > 0 && (max < 0 || n < max)) begin
         c = exp_q.pop_front();
         n++;
         opcode = c.op; zero = c.z; mem_ready = c.rdy; hold = c.hld;
         @(negedge clk);
         n_chk++;
         if (state !== c.st) $display("FAIL %s cyc%0d state: got %0d exp %0d", tag, n, state, c.st);
         else n_pass++;
         so = {pc_write, ir_write, mem_read, mem_write, reg_write, illegal, bus_error, retire};
         se = {c.pw, c.irw, c.mr, c.mw, c.rw, c.ill, c.berr, c.ret};
         n_chk++;
         if (so !== se) $display("FAIL %s cyc%0d strobes{pw,irw,mr,mw,rw,ill,berr,ret}: got %b exp %b", tag, n, so, se);
         else n_pass++;
         if (c.full) begin
            lo = {pc_src, i_or_d, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, sign_or_zero};
            le = {c.ps, c.iod, c.asa, c.asb, 1'b0, c.aop, c.rd, c.m2r, 1'b1};
            n_chk++;
            if (lo !== le) $display("FAIL %s cyc%0d selects{ps,iod,asa,asb,aop,rd,m2r,soz}: got %b exp %b", tag, n, lo, le);
            else n_pass++;
         end
         n_chk++;
         if (retired_cnt !== cnt_model) $display("FAIL %s cyc%0d retired_cnt: got %0d exp %0d", tag, n, retired_cnt, cnt_model);
         else n_pass++;
         if (c.ret && !c.hld) cnt_model++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      reset = 1; hold = 0; mem_ready = 0; opcode = '0; zero = 0; hold_en = 0;
      repeat (2) @(posedge clk);
      #1 hold = 1;
      @(negedge clk);
      n_chk++;
      if (state !== ST_IDLE) $display("FAIL reset state: got %0d exp 0", state);
      else n_pass++;
      n_chk++;
      if (retired_cnt !== 16'd0) $display("FAIL reset retired_cnt: got %0d exp 0", retired_cnt);
      else n_pass++;
      @(posedge clk); #1;
      reset = 0; hold = 0; cnt_model = '0;
      exp_q.push_back(blank(ST_IDLE, 8'h00, 1'b0));
      run_queue(-1, "reset_idle");
   endtask

   task automatic test_r_type;
      plan_instr(8'h00, 1'b0, 0, 0);
      run_queue(-1, "r_add");
      n_chk++;
      if (retired_cnt !== 16'd1) $display("FAIL r_add retired_cnt_after: got %0d exp 1", retired_cnt);
      else n_pass++;
   endtask

   task automatic test_lw_wait;
      plan_instr(8'h23, 1'b0, 0, 3);
      run_queue(-1, "lw_wait");
   endtask

   task automatic test_branch;
      plan_instr(8'h04, 1'b1, 0, 0);
      plan_instr(8'h05, 1'b1, 0, 0);
      plan_instr(8'h05, 1'b0, 1, 0);
      plan_instr(8'h04, 1'b0, 0, 0);
      run_queue(-1, "branch");
   endtask

   task automatic test_jal;
      plan_instr(8'h03, 1'b0, 0, 0);
      plan_instr(8'h02, 1'b1, 0, 0);
      run_queue(-1, "jump");
   endtask

   task automatic test_illegal;
      plan_instr(8'h3F, 1'b0, 0, 0);
      plan_instr(8'h48, 1'b0, 0, 0);
      plan_instr(8'h0D, 1'b0, 0, 0);
      run_queue(-1, "illegal");
   endtask

   task automatic test_timeout;
      plan_instr(8'h00, 1'b0, 5, 0);
      plan_instr(8'h08, 1'b0, 4, 0);
      plan_instr(8'h2B, 1'b0, 0, 5);
      plan_instr(8'h23, 1'b0, 0, 4);
      plan_instr(8'h0C, 1'b0, 11, 0);
      run_queue(-1, "timeout");
   endtask

   task automatic test_random;
      logic [7:0] op;
      hold_en = 1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) op = 8'($urandom);
         else op = legal_ops[$urandom_range(0, 11)];
         plan_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
         run_queue(-1, "random");
      end
      hold_en = 0;
   endtask

   task automatic test_reset_mid;
      plan_instr(8'h23, 1'b0, 0, 3);
      run_queue(4, "reset_mid_pre");
      exp_q.delete();
      reset = 1; hold = 1; mem_ready = 0;
      @(posedge clk); #1;
      reset = 0; hold = 0; cnt_model = '0;
      exp_q.push_back(blank(ST_IDLE, 8'h00, 1'b0));
      plan_instr(8'h2B, 1'b0, 0, 0);
      run_queue(-1, "reset_mid");
   endtask

   task automatic test_cnt_wrap;
      logic [5:0] ops[5];
      int         lat[5];
      ops = '{6'h00, 6'h04, 6'h02, 6'h2B, 6'h08};
      lat = '{4, 3, 3, 4, 4};
      reset_b = 1; hold_b = 0; mem_ready_b = 1; zero_b = 1; opcode_b = '0;
      @(posedge clk); #1;
      reset_b = 0;
      @(negedge clk);
      n_chk++;
      if ({pc_write_b, pc_src_b, ir_write_b, i_or_d_b, mem_read_b, mem_write_b, alu_src_a_b, alu_src_b_b,
           alu_op_b, reg_write_b, reg_dst_b, mem_to_reg_b, illegal_b, bus_error_b, retire_b,
           retired_cnt_b, state_b} !== 26'd0)
         $display("FAIL wrap idle_outputs: got nonzero exp all zero (state %0d cnt %0d)", state_b, retired_cnt_b);
      else n_pass++;
      n_chk++;
      if (sign_or_zero_b !== 1'b1) $display("FAIL wrap idle_sign_or_zero: got %b exp 1", sign_or_zero_b);
      else n_pass++;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         opcode_b = ops[i];
         for (int c = 0; c < lat[i]; c++) begin
            @(negedge clk);
            n_chk++;
            if (retire_b !== (c == lat[i] - 1)) $display("FAIL wrap retire instr%0d cyc%0d: got %b exp %b", i, c, retire_b, (c == lat[i] - 1));
            else n_pass++;
            @(posedge clk); #1;
         end
         n_chk++;
         if (retired_cnt_b !== 2'((i + 1) % 4)) $display("FAIL wrap retired_cnt instr%0d: got %0d exp %0d", i, retired_cnt_b, (i + 1) % 4);
         else n_pass++;
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cnt_model = '0; hold_en = 0;
      legal_ops = '{8'h00, 8'h08, 8'h18, 8'h0A, 8'h0C, 8'h0D, 8'h23, 8'h2B, 8'h04, 8'h05, 8'h02, 8'h03};
      reset_b = 1; hold_b = 0; mem_ready_b = 1; zero_b = 0; opcode_b = '0;
      test_reset;
      test_r_type;
      test_lw_wait;
      test_branch;
      test_jal;
      test_illegal;
      test_timeout;
      test_random;
      test_reset_mid;
      test_cnt_wrap;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mips16_mc_control.md
Name: mips16_mc_control

Overview:
- Multi-cycle successor to the single-cycle MIPS16 main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes state by state.
- Waits on a ready handshake for memory, with an optional wait-timeout, and counts retired instructions.
- Sits between the instruction register / shared memory port and the multi-cycle datapath.

Parameters:
- OPCODE_W, 6, opcode width. Must be >= 6. Bits above [5:0] must be zero for a legal opcode.
- ALU_OP_W, 3, alu_op width. Must be >= 3. Upper bits are driven zero.
- MEM_TIMEOUT, 0, max wait cycles on mem_ready in FETCH/MEM. 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  IR opcode field, sampled in DECODE
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- hold  in  1  freezes state, counters and opcode_q. All strobes are forced 0 while high.
- pc_write  out  1  PC load enable
- pc_src  out  2  00 = PC+inc, 01 = branch target, 10 = jump target
- ir_write  out  1  IR load enable
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALU out
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = constant inc, 10 = immediate
- alu_op  out  ALU_OP_W  ALU operation
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $ra
- mem_to_reg  out  2  00 = ALU, 01 = memory, 10 = PC
- sign_or_zero  out  1  1 = sign-extend immediate
- illegal  out  1  1-cycle pulse on an undecodable opcode
- bus_error  out  1  1-cycle pulse on timeout
- retire  out  1  1-cycle pulse when an instruction completes
- retired_cnt  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
- state  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, JUMP=7

Behaviour:
- Reset: synchronous, active-high. On the reset edge: state=IDLE, opcode_q=0, wait counter=0, retired_cnt=0.
- While in IDLE, all strobes and pulses are 0, alu_op=0, pc_src/reg_dst/mem_to_reg/alu_src_b=0, sign_or_zero=1.
- Reset mid-instruction aborts it with no retire. Reset beats hold.
- Outputs are Moore-decoded from state and opcode_q. Signals not listed for a state are 0, except sign_or_zero=1 always.
- IDLE -> FETCH unconditionally.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: opcode_q <= opcode. Next state:
  - 000000 (R), 001000 (addi), 011000 (li), 001010 (slti), 001100 (andi), 001101 (ori), 100011 (lw), 101011 (sw) -> EXEC
  - 000100 (beq), 000101 (bne) -> BRANCH
  - 000010 (j), 000011 (jal) -> JUMP
  - any other value -> FETCH with illegal=1 for that cycle, no retire.
- EXEC: alu_src_a=1. alu_src_b=00 for R, else 10.
  - alu_op: R=110; addi/li/lw/sw=000; slti=101; andi=010; ori=011.
  - Next state: lw/sw -> MEM, else -> WB.
- MEM: i_or_d=1. mem_read=1 for lw, mem_write=1 for sw, held until mem_ready.
  - On ready: lw -> WB; sw -> FETCH with retire.
- WB: reg_write=1. reg_dst=01 for R, else 00. mem_to_reg=01 for lw, else 00. Retire, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01.
  - pc_write = (beq & zero) | (bne & ~zero).
  - Retire, then -> FETCH.
- JUMP: pc_write=1, pc_src=10.
  - jal additionally asserts reg_write=1, reg_dst=10, mem_to_reg=10.
  - Retire, then -> FETCH.
- Retire: retire=1 in the completing cycle. retired_cnt increments on the same edge and wraps all-ones -> 0.
- Wait counter: counts cycles in FETCH/MEM with mem_ready=0; clears on ready or on leaving the state.
  - When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT, the next edge goes to FETCH. bus_error=1 in that cycle, strobes are forced 0, no retire, and the counter clears.
  - mem_ready arriving on the timeout cycle wins: the access completes normally and there is no error.
- hold=1: no state change, counters frozen, all strobes 0, pulses 0. The access resumes when hold drops.
- Latency with mem_ready tied high: R/imm = 4 cycles; lw = 5; sw = 4; beq/bne/j/jal = 3.

Test Plan:
- R-type add (opcode 0), mem_ready=1 -> states 1,2,3,5,1. EXEC alu_op=110, alu_src_b=00. WB reg_write=1, reg_dst=01. retire at cycle 4; retired_cnt 0->1.
- lw with mem_ready low for 3 MEM cycles -> MEM holds mem_read=1, i_or_d=1 for 4 cycles. WB mem_to_reg=01. Total 8 cycles.
- beq with zero=1 -> pc_write=1, pc_src=01. bne with zero=1 -> pc_write=0. Both retire.
- jal -> JUMP with pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- Opcode 111111 -> illegal pulse in DECODE, return to FETCH, retired_cnt unchanged.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH -> bus_error after 4 wait cycles, back in FETCH.
- Separately: reset asserted during MEM -> state=0, retired_cnt=0 next cycle.
- CNT_W=2: 5 instructions -> retired_cnt ends at 1.
